// File: rtl/hotp_verifier.sv
// hotp_verifier: checks a submitted 6-digit HOTP code against WINDOW consecutive counters starting at counter_base.
// Latency: 2 cycles for an out-of-range code; otherwise (k+1) core runs of ~338 cycles plus ARM/CHECK overhead, plus 1, for a match at offset k.
// Backpressure: none; start is taken only in IDLE outside the done cycle and is silently dropped otherwise.

// hotp_core: HMAC-SHA1 of an 8-byte counter, dynamic truncation, then mod 1_000_000.
// Latency: 4 SHA-1 blocks of 81 cycles, 1 truncation cycle, 12 division cycles after rst falls.
// Backpressure: none; inputs must stay stable while rst is low, and the result holds until rst is raised.
module hotp_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key,
  input  logic [63:0]  cnt,
  output logic [19:0]  code,
  output logic         done
);
  localparam logic [159:0] SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [2:0] {C_LOAD, C_ROUND, C_TRUNC, C_DIV, C_DONE} core_state_t;

  core_state_t  state_q, state_d;
  logic [1:0]   blk_q;
  logic [6:0]   rnd_q;
  logic [3:0]   div_q;
  logic [159:0] h_q, ih_q;
  logic [31:0]  a_q, b_q, c_q, d_q, e_q;
  logic [31:0]  w_q [16];
  logic [31:0]  rem_q;
  logic [511:0] blk;
  logic [31:0]  f, k, temp, w_x, w_new, trunc_w, sub_val;
  logic [159:0] h_sum;
  logic [7:0]   sh_amt;

  assign code = rem_q[19:0];
  assign done = (state_q == C_DONE);

  // Sequencer state register; rst parks the core ready to start block 0.
  always_ff @(posedge clk) begin
    if (rst) state_q <= C_LOAD;
    else     state_q <= state_d;
  end

  // Sequencer: load block, 80 rounds, repeat for 4 blocks, then truncate and reduce.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_LOAD:  state_d = C_ROUND;
      C_ROUND: if (rnd_q == 7'd79) state_d = (blk_q == 2'd3) ? C_TRUNC : C_LOAD;
      C_TRUNC: state_d = C_DIV;
      C_DIV:   if (div_q == 4'd0) state_d = C_DONE;
      default: state_d = C_DONE;
    endcase
  end

  // Block selection, SHA-1 round function, schedule expansion and truncation.
  always_comb begin
    case (blk_q)
      2'd0:    blk = key ^ {64{8'h36}};
      2'd1:    blk = {cnt, 8'h80, 376'd0, 64'd576};
      2'd2:    blk = key ^ {64{8'h5c}};
      default: blk = {ih_q, 8'h80, 280'd0, 64'd672};
    endcase
    f = b_q ^ c_q ^ d_q;
    k = 32'hCA62C1D6;
    if (rnd_q < 7'd20) begin
      f = (b_q & c_q) | (~b_q & d_q);
      k = 32'h5A827999;
    end else if (rnd_q < 7'd40) begin
      k = 32'h6ED9EBA1;
    end else if (rnd_q < 7'd60) begin
      f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k = 32'h8F1BBCDC;
    end
    temp  = {a_q[26:0], a_q[31:27]} + f + e_q + k + w_q[0];
    w_x   = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
    w_new = {w_x[30:0], w_x[31]};
    h_sum = {h_q[159:128] + temp, h_q[127:96] + a_q, h_q[95:64] + {b_q[1:0], b_q[31:2]},
             h_q[63:32] + c_q, h_q[31:0] + d_q};
    // byte offset o selects bytes o..o+3 of the digest: shift right by 8*(16-o)
    sh_amt  = {1'b0, ~h_q[3:0], 3'b000} + 8'd8;
    trunc_w = 32'(h_q >> sh_amt);
    sub_val = 32'd1000000 << div_q;
  end

  // Hash datapath; the inner digest is parked in ih_q while the outer hash restarts from the IV.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= 2'd0;
      rnd_q <= 7'd0;
      h_q   <= SHA1_IV;
    end else begin
      case (state_q)
        C_LOAD: begin
          for (int i = 0; i < 16; i++) w_q[i] <= blk[511 - 32*i -: 32];
          {a_q, b_q, c_q, d_q, e_q} <= h_q;
          rnd_q <= 7'd0;
        end
        C_ROUND: begin
          a_q <= temp;
          b_q <= a_q;
          c_q <= {b_q[1:0], b_q[31:2]};
          d_q <= c_q;
          e_q <= d_q;
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new;
          rnd_q   <= rnd_q + 7'd1;
          if (rnd_q == 7'd79) begin
            blk_q <= blk_q + 2'd1;
            if (blk_q == 2'd1) begin
              ih_q <= h_sum;
              h_q  <= SHA1_IV;
            end else begin
              h_q <= h_sum;
            end
          end
        end
        C_TRUNC: begin
          rem_q <= trunc_w & 32'h7FFF_FFFF;
          div_q <= 4'd11;
        end
        C_DIV: begin
          // restoring reduction: quotient is below 2^12, so 12 conditional subtracts suffice
          if (rem_q >= sub_val) rem_q <= rem_q - sub_val;
          div_q <= div_q - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

module hotp_verifier #(
  parameter int WINDOW = 10,
  parameter int OFS_W  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] key,
  input  logic [63:0]  counter_base,
  input  logic [19:0]  candidate,
  output logic         busy,
  output logic         done,
  output logic         match,
  output logic [63:0]  matched_counter,
  output logic [63:0]  next_counter
);
  typedef enum logic [2:0] {IDLE, ARM, RUN, CHECK, FOUND, FAIL} state_t;

  state_t           state_q, state_d;
  logic [511:0]     key_q;
  logic [63:0]      base_q, cnt_q;
  logic [19:0]      cand_q;
  logic [OFS_W-1:0] ofs_q;
  logic             core_rst, core_done, accept, hit, last_ofs;
  logic [19:0]      code;

  assign accept   = start && (state_q == IDLE) && !done;
  assign hit      = (code == cand_q);
  assign last_ofs = (ofs_q == OFS_W'(WINDOW - 1));
  assign busy     = (state_q != IDLE);

  hotp_core u_core (
    .clk  (clk),
    .rst  (core_rst),
    .key  (key_q),
    .cnt  (cnt_q),
    .code (code),
    .done (core_done)
  );

  // Search FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; the core runs only in RUN, so each RUN entry is exactly one counter tried.
  always_comb begin
    state_d  = state_q;
    core_rst = 1'b1;
    case (state_q)
      IDLE:  if (accept) state_d = (candidate >= 20'd1000000) ? FAIL : ARM;
      ARM:   if (!core_done) state_d = RUN;
      RUN: begin
        core_rst = 1'b0;
        if (core_done) state_d = CHECK;
      end
      CHECK: begin
        if (hit)           state_d = FOUND;
        else if (last_ofs) state_d = FAIL;
        else               state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, counter stepping and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      done            <= 1'b0;
      match           <= 1'b0;
      matched_counter <= 64'd0;
      next_counter    <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          key_q  <= key;
          base_q <= counter_base;
          cand_q <= candidate;
          cnt_q  <= counter_base;
          ofs_q  <= '0;
        end
        CHECK: if (!hit && !last_ofs) begin
          ofs_q <= ofs_q + OFS_W'(1);
          cnt_q <= cnt_q + 64'd1;
        end
        FOUND: begin
          done            <= 1'b1;
          match           <= 1'b1;
          matched_counter <= cnt_q;
          next_counter    <= cnt_q + 64'd1;
        end
        FAIL: begin
          done            <= 1'b1;
          match           <= 1'b0;
          matched_counter <= 64'd0;
          next_counter    <= base_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hotp_verifier.sv
// tb_hotp_verifier: scoreboard bench for hotp_verifier.
// Expected results are queued when a request is driven and compared when done pulses.
// Core runs are counted as falling edges of the internal core reset.
`timescale 1ns/1ps
module tb_hotp_verifier;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [511:0] key = '0;
  logic [63:0]  counter_base = '0;
  logic [19:0]  candidate = '0;
  logic         busy, done, match;
  logic [63:0]  matched_counter, next_counter;

  typedef struct {
    logic        m;
    logic [63:0] mc;
    logic [63:0] nc;
    int          runs;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_at_start = 0;
  int   runs = 0;
  logic prev_rst = 1'b1;

  localparam logic [103:0] HELLO   = "Hello, world!";
  localparam logic [31:0]  LEIA    = "Leia";
  localparam logic [511:0] K_HELLO = {HELLO, 408'd0};
  localparam logic [511:0] K_LEIA  = {LEIA, 480'd0};

  hotp_verifier #(.WINDOW(10), .OFS_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .key             (key),
    .counter_base    (counter_base),
    .candidate       (candidate),
    .busy            (busy),
    .done            (done),
    .match           (match),
    .matched_counter (matched_counter),
    .next_counter    (next_counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, want, want);
    end
  endtask

  function automatic exp_t mk(input logic m, input logic [63:0] mc, input logic [63:0] nc, input int r);
    exp_t e;
    e.m = m; e.mc = mc; e.nc = nc; e.runs = r;
    return e;
  endfunction

  task automatic run_req(input logic [511:0] k, input logic [63:0] b, input logic [19:0] c, input exp_t e);
    @(negedge clk);
    key = k; counter_base = b; candidate = c; start = 1'b1;
    runs = 0;
    n_at_start = n_done;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int tmo);
    int i;
    i = 0;
    while (n_done == n_at_start && i < tmo) begin
      @(posedge clk);
      i++;
    end
    check("done_within_budget", (n_done != n_at_start), 1);
  endtask

  // Monitor: count core runs and score every done pulse against the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (prev_rst && !dut.core_rst) runs++;
    prev_rst = dut.core_rst;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("match", match, e.m);
        check("matched_counter", matched_counter, e.mc);
        check("next_counter", next_counter, e.nc);
        check("core_runs", runs, e.runs);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int nd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_mc", matched_counter, 0);
    check("rst_nc", next_counter, 0);
    check("rst_core_rst", dut.core_rst, 1);
    reset = 1'b0;

    // match at the first counter
    run_req(K_HELLO, 64'd0, 20'd557396, mk(1'b1, 64'd0, 64'd1, 1));
    wait_done(6000);

    // match at offset 4
    run_req(K_LEIA, 64'd1230, 20'd35954, mk(1'b1, 64'd1234, 64'd1235, 5));
    wait_done(6000);

    // whole window misses; previous result must hold while searching
    run_req(K_LEIA, 64'd1235, 20'd35954, mk(1'b0, 64'd0, 64'd1235, 10));
    repeat (3) @(negedge clk);
    check("hold_busy", busy, 1);
    check("hold_match", match, 1);
    check("hold_mc", matched_counter, 64'd1234);
    check("hold_nc", next_counter, 64'd1235);
    wait_done(6000);

    // out-of-range candidate: fails 2 cycles after start, core never runs
    run_req(K_HELLO, 64'd77, 20'd1000000, mk(1'b0, 64'd0, 64'd77, 0));
    check("oor_cycle1_done", done, 0);
    check("oor_cycle1_busy", busy, 1);
    @(negedge clk);
    check("oor_cycle2_done", done, 1);
    check("oor_cycle2_core_rst", dut.core_rst, 1);

    // second start mid-search is ignored
    run_req(K_HELLO, 64'd0, 20'd557396, mk(1'b1, 64'd0, 64'd1, 1));
    nd0 = n_at_start;
    repeat (20) @(negedge clk);
    key = K_LEIA; counter_base = 64'd1230; candidate = 20'd35954; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6000);
    repeat (5) @(negedge clk);
    check("single_done_pulse", n_done - nd0, 1);
    check("after_ignored_busy", busy, 0);

    // start during the done cycle is ignored
    run_req(K_LEIA, 64'd1230, 20'd35954, mk(1'b1, 64'd1234, 64'd1235, 5));
    i = 0;
    while (!done && i < 6000) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", done, 1);
    key = K_HELLO; counter_base = 64'd0; candidate = 20'd557396; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_done_busy", busy, 0);
    check("start_in_done_mc", matched_counter, 64'd1234);

    // reset during the second core run, then a fresh request
    run_req(K_LEIA, 64'd1230, 20'd35954, mk(1'b1, 64'd1234, 64'd1235, 5));
    i = 0;
    while (runs < 2 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("second_run_reached", (runs >= 2), 1);
    repeat (5) @(negedge clk);
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_match", match, 0);
    check("mid_rst_mc", matched_counter, 0);
    check("mid_rst_nc", next_counter, 0);
    check("mid_rst_core_rst", dut.core_rst, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_req(K_LEIA, 64'd1230, 20'd35954, mk(1'b1, 64'd1234, 64'd1235, 5));
    wait_done(6000);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
